// File: rtl/be_block_assembler_pkg.sv
// Shared types and helpers for the word-serial to big-endian block assembler.
// The helpers take the word width as an argument so one package serves every instance.
package be_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } be_state_t;

    // Widest word the byte-swap helper handles; instances assert against it.
    localparam int BSWAP_MAX_W = 512;

    function automatic logic [BSWAP_MAX_W-1:0] bswap(input logic [BSWAP_MAX_W-1:0] word,
                                                     input int word_w);
        logic [BSWAP_MAX_W-1:0] res;
        res = '0;
        for (int b = 0; b < word_w / 8; b++) begin
            res[(word_w/8 - 1 - b)*8 +: 8] = word[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic int slot_of(input int idx, input logic wrev, input int num_words);
        return wrev ? (num_words - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/be_block_assembler_if.sv
// Word-in / block-out handshake bundle for be_block_assembler.
interface be_block_assembler_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [WORD_W-1:0]           in_word;
    logic                        in_last;
    logic                        mode_bswap;
    logic                        mode_wrev;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_WORDS*WORD_W-1:0] out_block;
    logic                        out_err_short;
    logic                        out_err_long;

    modport master (
        output in_valid, in_word, in_last, mode_bswap, mode_wrev, out_ready,
        input  in_ready, out_valid, out_block, out_err_short, out_err_long
    );

    modport slave (
        input  in_valid, in_word, in_last, mode_bswap, mode_wrev, out_ready,
        output in_ready, out_valid, out_block, out_err_short, out_err_long
    );
endinterface

// File: rtl/be_block_assembler_word_swap.sv
// Combinational byte reverse of one WORD_W-bit word with a pass-through select.
module be_word_swap
    import be_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] din,
    input  logic              swap_en,
    output logic [WORD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (swap_en) begin
            dout = WORD_W'(bswap(BSWAP_MAX_W'(din), WORD_W));
        end
    end

endmodule

// File: rtl/be_block_assembler.sv
// Assembles a stream of words into a NUM_WORDS-word block with optional byte swap
// and reversed word placement, flagging short and over-long blocks.
module be_block_assembler
    import be_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 16,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input logic             clk,
    input logic             rst_n,
    be_block_assembler_if.slave bus
);

    localparam int BLK_W = NUM_WORDS * WORD_W;

    if (WORD_W < 8 || (WORD_W % 8) != 0) begin : g_bad_word_w
        $error("be_block_assembler: WORD_W must be a multiple of 8 and at least 8");
    end
    if (WORD_W > BSWAP_MAX_W) begin : g_word_too_wide
        $error("be_block_assembler: WORD_W exceeds BSWAP_MAX_W");
    end
    if (NUM_WORDS < 2) begin : g_bad_num_words
        $error("be_block_assembler: NUM_WORDS must be at least 2");
    end

    be_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              es_q, es_d, el_q, el_d;
    logic              drain_q, drain_d;
    logic              bsw_q, bsw_d, wrev_q, wrev_d;
    logic              rdy_q;
    logic              eff_bswap, eff_wrev;
    logic              in_ready_w, accept;
    logic [WORD_W-1:0] word_sw;
    int                slot;

    // The first word of a block uses the live modes; later words use the latched ones.
    assign eff_bswap = (idx_q == '0) ? bus.mode_bswap : bsw_q;
    assign eff_wrev  = (idx_q == '0) ? bus.mode_wrev  : wrev_q;
    assign slot      = slot_of(int'(idx_q), eff_wrev, NUM_WORDS);

    be_word_swap #(.WORD_W(WORD_W)) u_swap (
        .din     (bus.in_word),
        .swap_en (eff_bswap),
        .dout    (word_sw)
    );

    // rdy_q keeps in_ready low through reset and the first edge after release.
    assign in_ready_w = rdy_q & ((state_q == HOLD) ? (bus.out_ready & ~drain_q) : 1'b1);
    assign accept     = bus.in_valid & in_ready_w;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        es_d    = es_q;
        el_d    = el_q;
        drain_d = drain_q;
        bsw_d   = bsw_q;
        wrev_d  = wrev_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    blk_d[slot*WORD_W +: WORD_W] = word_sw;
                    if (idx_q == '0) begin
                        bsw_d  = bus.mode_bswap;
                        wrev_d = bus.mode_wrev;
                    end
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        if (!bus.in_last) begin
                            el_d    = 1'b1;
                            drain_d = 1'b1;
                        end
                    end else if (bus.in_last) begin
                        // Unwritten slots are already zero: the block is cleared on handover.
                        state_d = HOLD;
                        idx_d   = '0;
                        es_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    blk_d   = '0;
                    es_d    = 1'b0;
                    el_d    = 1'b0;
                    idx_d   = '0;
                    state_d = drain_q ? DRAIN : FILL;
                    if (accept) begin
                        blk_d[slot*WORD_W +: WORD_W] = word_sw;
                        bsw_d  = bus.mode_bswap;
                        wrev_d = bus.mode_wrev;
                        if (bus.in_last) begin
                            state_d = HOLD;
                            es_d    = 1'b1;
                        end else begin
                            idx_d = IDX_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept && bus.in_last) begin
                    drain_d = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            blk_q   <= '0;
            es_q    <= 1'b0;
            el_q    <= 1'b0;
            drain_q <= 1'b0;
            bsw_q   <= 1'b0;
            wrev_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            es_q    <= es_d;
            el_q    <= el_d;
            drain_q <= drain_d;
            bsw_q   <= bsw_d;
            wrev_q  <= wrev_d;
            rdy_q   <= 1'b1;
        end
    end

    assign bus.in_ready      = in_ready_w;
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.out_block     = blk_q;
    assign bus.out_err_short = es_q;
    assign bus.out_err_long  = el_q;

endmodule

// File: tb/tb_be_block_assembler.sv
// Self-checking bench for be_block_assembler: directed scenarios plus randomized
// blocks checked against a list-based block model.
module tb_be_block_assembler;

    localparam int W = 32;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    be_block_assembler_if #(.WORD_W(W), .NUM_WORDS(N)) bus ();

    be_block_assembler #(.WORD_W(W), .NUM_WORDS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [N*W-1:0] blk;
        logic           es;
        logic           el;
    } blk_t;

    blk_t       exp_q[$];
    blk_t       got_q[$];
    logic [W-1:0] m_words[$];
    logic       m_bs, m_wr, m_drain;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       in_acc_s, out_acc_s;

    function automatic logic [W-1:0] ref_swap(input logic [W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Model: collect accepted words of a block, build the block when it closes.
    task automatic model_accept(input logic [W-1:0] w, input logic l, input logic bs, input logic wr);
        blk_t e;
        if (m_drain) begin
            if (l) m_drain = 1'b0;
            return;
        end
        if (m_words.size() == 0) begin
            m_bs = bs;
            m_wr = wr;
        end
        m_words.push_back(w);
        if (l || m_words.size() == N) begin
            e.blk = '0;
            foreach (m_words[i])
                e.blk[(m_wr ? N-1-i : i)*W +: W] = m_bs ? ref_swap(m_words[i]) : m_words[i];
            e.es = l && (m_words.size() < N);
            e.el = !l;
            if (!l) m_drain = 1'b1;
            exp_q.push_back(e);
            m_words.delete();
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_drain = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] w, input logic l,
                         input logic bs, input logic wr, input logic ordy);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_word    = w;
        bus.in_last    = l;
        bus.mode_bswap = bs;
        bus.mode_wrev  = wr;
        bus.out_ready  = ordy;
        #1;
        in_acc_s  = v & bus.in_ready;
        out_acc_s = bus.out_valid & ordy;
        if (out_acc_s) got_q.push_back({bus.out_block, bus.out_err_short, bus.out_err_long});
        if (in_acc_s) model_accept(w, l, bs, wr);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input logic l, input logic bs,
                        input logic wr, input logic ordy);
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, w, l, bs, wr, ordy);
            if (in_acc_s) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: word %h not accepted within 50 cycles", w);
    endtask

    task automatic flush();
        for (int k = 0; k < 20; k++) begin
            if (!bus.out_valid) break;
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_word = '0; bus.in_last = 0;
        bus.mode_bswap = 0; bus.mode_wrev = 0; bus.out_ready = 0;
        #12;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_err_short, bus.out_err_long} !== 4'b0000
            || bus.out_block !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b es=%b el=%b blk_nonzero=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.out_err_short, bus.out_err_long, bus.out_block != '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_edge_ready: got %b, required 1", bus.in_ready);
        end
        model_reset();
    endtask

    task automatic test_full(input logic bs, input logic wr,
                             input logic [W-1:0] exp_top, input logic [W-1:0] exp_bot);
        for (int i = 0; i < N; i++) send(32'h01234500 + i, (i == N-1), bs, wr, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_err_short !== 1'b0 || bus.out_err_long !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flags bs=%b wr=%b: vld=%b es=%b el=%b, required 1 0 0",
                     bs, wr, bus.out_valid, bus.out_err_short, bus.out_err_long);
        end
        n_tests++;
        if (bus.out_block[N*W-1 -: W] !== exp_top || bus.out_block[W-1:0] !== exp_bot) begin
            n_fail++;
            $display("FAIL full_spot bs=%b wr=%b: top=%h bot=%h, required %h %h",
                     bs, wr, bus.out_block[N*W-1 -: W], bus.out_block[W-1:0], exp_top, exp_bot);
        end
        n_tests++;
        if (exp_q.size() != 1 || bus.out_block !== exp_q[0].blk) begin
            n_fail++;
            $display("FAIL full_block bs=%b wr=%b: got %h, model blocks %0d", bs, wr, bus.out_block, exp_q.size());
        end
        flush();
        model_reset();
    endtask

    task automatic test_short();
        logic [N*W-1:0] upper;
        send(32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (in_acc_s !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL short_latency: acc=%b vld=%b after closing accept, required 1 1", in_acc_s, bus.out_valid);
        end
        n_tests++;
        if (bus.out_err_short !== 1'b1 || bus.out_err_long !== 1'b0) begin
            n_fail++;
            $display("FAIL short_flags: es=%b el=%b, required 1 0", bus.out_err_short, bus.out_err_long);
        end
        upper = bus.out_block >> (3*W);
        n_tests++;
        if (upper !== '0 || bus.out_block[3*W-1:0] !== {32'h33333333, 32'h22222222, 32'h11111111}) begin
            n_fail++;
            $display("FAIL short_slots: got %h", bus.out_block);
        end
        flush();
        model_reset();
    endtask

    task automatic test_long();
        for (int i = 0; i < N; i++) send(32'h50000000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_err_long !== 1'b1 || bus.out_err_short !== 1'b0) begin
            n_fail++;
            $display("FAIL long_flags: vld=%b es=%b el=%b, required 1 0 1",
                     bus.out_valid, bus.out_err_short, bus.out_err_long);
        end
        cycle(1'b1, 32'h50000010, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (in_acc_s !== 1'b0 || out_acc_s !== 1'b1) begin
            n_fail++;
            $display("FAIL long_handover: in_acc=%b out_acc=%b, required 0 1", in_acc_s, out_acc_s);
        end
        send(32'h50000010, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'h50000011, 1'b1, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL long_drain_discard: vld=%b, required 0", bus.out_valid);
        end
        send(32'hAABBCCDD, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_block[W-1:0] !== 32'hDDCCBBAA || bus.out_err_short !== 1'b1) begin
            n_fail++;
            $display("FAIL long_next_word: vld=%b slot0=%h es=%b, required 1 ddccbbaa 1",
                     bus.out_valid, bus.out_block[W-1:0], bus.out_err_short);
        end
        flush();
        n_tests++;
        if (got_q.size() != 2 || exp_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL long_blocks: got %0d blocks, model %0d", got_q.size(), exp_q.size());
        end
        model_reset();
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] snap, want;
        logic [W-1:0]   x;
        for (int i = 0; i < 5; i++) send($urandom, (i == 4), 1'($urandom), 1'($urandom), 1'b0);
        snap = bus.out_block;
        x = $urandom;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, x, 1'b0, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (in_acc_s !== 1'b0 || bus.out_block !== snap || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stall c=%0d: acc=%b vld=%b stable=%b, required 0 1 1",
                         c, in_acc_s, bus.out_valid, bus.out_block === snap);
            end
        end
        cycle(1'b1, x, 1'b0, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (in_acc_s !== 1'b1 || out_acc_s !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: in_acc=%b out_acc=%b, required 1 1", in_acc_s, out_acc_s);
        end
        want = '0;
        want[N*W-1 -: W] = ref_swap(x);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_block !== want) begin
            n_fail++;
            $display("FAIL b2b_new_block: vld=%b top=%h, required 0 %h", bus.out_valid, bus.out_block[N*W-1 -: W], ref_swap(x));
        end
        send($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        flush();
        n_tests++;
        if (got_q.size() != 2 || exp_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL b2b_blocks: got %0d blocks, model %0d", got_q.size(), exp_q.size());
        end
        model_reset();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) send($urandom, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_err_short, bus.out_err_long} !== 4'b0000
            || bus.out_block !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: rdy=%b vld=%b es=%b el=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.out_err_short, bus.out_err_long);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) send(32'hC0DE0000 + i, (i == N-1), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.out_block[W-1:0] !== 32'hC0DE0000 || bus.out_err_short !== 1'b0 || bus.out_err_long !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: slot0=%h es=%b el=%b, required c0de0000 0 0",
                     bus.out_block[W-1:0], bus.out_err_short, bus.out_err_long);
        end
        flush();
        n_tests++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_mid_blocks: got %0d blocks, model %0d", got_q.size(), exp_q.size());
        end
        model_reset();
    endtask

    task automatic test_random();
        int len;
        logic [W-1:0] w;
        logic got_it;
        for (int b = 0; b < 10; b++) begin
            len = $urandom_range(1, 18);
            for (int k = 0; k < len; k++) begin
                w = $urandom;
                got_it = 1'b0;
                for (int t = 0; t < 100 && !got_it; t++) begin
                    cycle(1'($urandom_range(0, 3) != 0), w, (k == len-1),
                          1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
                    got_it = in_acc_s;
                end
                if (!got_it) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL random_timeout: block %0d word %0d", b, k);
                end
            end
        end
        flush();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d blocks, model %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_block %0d: got es=%b el=%b %h, required es=%b el=%b %h",
                         i, got_q[i].es, got_q[i].el, got_q[i].blk, exp_q[i].es, exp_q[i].el, exp_q[i].blk);
            end
        end
        model_reset();
    endtask

    initial begin
        test_reset();
        test_full(1'b1, 1'b0, 32'h0F452301, 32'h00452301);
        test_full(1'b0, 1'b1, 32'h01234500, 32'h0123450F);
        test_short();
        test_long();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
